// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory access controller.
//   - request size codes (byte / halfword / word; 2'b11 is reserved)
//   - controller state encoding
//   - default DataMemory depth in 32-bit words
//   - CPU request bundle
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_DEPTH = 258;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/subword_lane.sv
// subword_lane: big-endian lane logic shared by the load and store paths.
//   word      in  32  memory word (DataOut)
//   addr      in  2   byte offset within the word (0 selects [31:24])
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_signed in  1   sign-extend sub-word extracts
//   wdata     in  32  store data, sub-word data in the low bits
//   extract   out 32  aligned, extended load data
//   merge     out 32  word with the addressed lane replaced by wdata
module subword_lane
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] extract,
    output logic [31:0] merge
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = word[31:24];
            2'd1:    byte_lane = word[23:16];
            2'd2:    byte_lane = word[15:8];
            default: byte_lane = word[7:0];
        endcase
        half_lane = addr[1] ? word[15:0] : word[31:16];

        extract = word;
        merge   = wdata;
        case (size)
            SZ_BYTE: begin
                extract = {{24{is_signed & byte_lane[7]}}, byte_lane};
                merge   = word;
                case (addr)
                    2'd0:    merge[31:24] = wdata[7:0];
                    2'd1:    merge[23:16] = wdata[7:0];
                    2'd2:    merge[15:8]  = wdata[7:0];
                    default: merge[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                extract = {{16{is_signed & half_lane[15]}}, half_lane};
                merge   = word;
                if (addr[1]) merge[15:0]  = wdata[15:0];
                else         merge[31:16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU byte-addressed load/store front end for a
// word-organised DataMemory.
//   CLK, RST                    clock, asynchronous active-low reset
//   req_*                       CPU request (valid, we, size, signed, addr, wdata)
//   rdata, stall                load result and CPU hold
//   mRD, mWR, DataAddr, DataIn  DataMemory control (memory writes on negedge)
//   DataOut                     DataMemory combinational read data
//   fault, fault_addr           sticky fault flag and first faulting address
// Loads and word stores take one cycle. Byte/halfword stores read the word
// (cycle A, stalled), then write the merged word from a buffer (cycle B).
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = 9
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mRD,
    output logic        mWR,
    output logic [31:0] DataAddr,
    output logic [31:0] DataIn,
    input  logic [31:0] DataOut,
    output logic        fault,
    output logic [31:0] fault_addr
);

    state_t            state_q, state_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic              fault_q, fault_d;
    logic [31:0]       fault_addr_q, fault_addr_d;

    mem_req_t          req;
    logic [IDX_W-1:0]  idx;
    logic              misalign, out_of_range, in_idle, legal, bad, sub_store;
    logic [31:0]       lane_rd, lane_wr;

    assign req = '{valid: req_valid, we: req_we, size: req_size, sgn: req_signed,
                   addr: req_addr, wdata: req_wdata};
    assign idx = req.addr[IDX_W+1:2];

    assign misalign     = (req.size == 2'b11)
                        | ((req.size == SZ_HALF) & req.addr[0])
                        | ((req.size == SZ_WORD) & (|req.addr[1:0]));
    assign out_of_range = (req.addr[31:2] >= 30'(DEPTH));
    // Request inputs only matter in IDLE; cycle B ignores them entirely.
    assign in_idle   = (state_q == ST_IDLE);
    assign legal     = in_idle & req.valid & ~misalign & ~out_of_range;
    assign bad       = in_idle & req.valid & (misalign | out_of_range);
    assign sub_store = legal & req.we & (req.size != SZ_WORD);

    subword_lane u_lane (
        .word      (DataOut),
        .addr      (req.addr[1:0]),
        .size      (req.size),
        .is_signed (req.sgn),
        .wdata     (req.wdata),
        .extract   (lane_rd),
        .merge     (lane_wr)
    );

    // State register and datapath flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            wbuf_q       <= '0;
            widx_q       <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            wbuf_q       <= wbuf_d;
            widx_q       <= widx_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Next state and register updates.
    always_comb begin
        state_d      = state_q;
        wbuf_d       = wbuf_q;
        widx_d       = widx_q;
        fault_d      = fault_q | bad;
        fault_addr_d = (bad & ~fault_q) ? req.addr : fault_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (sub_store) begin
                    state_d = ST_RMW_WR;
                    wbuf_d  = lane_wr;
                    widx_d  = idx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        rdata    = '0;
        stall    = 1'b0;
        mRD      = 1'b0;
        mWR      = 1'b0;
        DataAddr = '0;
        DataIn   = '0;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    DataAddr = 32'(idx);
                    if (!req.we) begin
                        mRD   = 1'b1;
                        rdata = lane_rd;
                    end else if (req.size == SZ_WORD) begin
                        mWR    = 1'b1;
                        DataIn = req.wdata;
                    end else begin
                        mRD   = 1'b1;
                        stall = 1'b1;
                    end
                end
            end
            default: begin
                mWR      = 1'b1;
                DataAddr = 32'(widx_q);
                DataIn   = wbuf_q;
            end
        endcase
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: holds a DataMemory, a behavioural model of the
// controller and memory, a per-cycle compare process, and directed cases.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int DEPTH = 258;
    localparam int IDX_W = 9;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata, DataAddr, DataIn, DataOut, fault_addr;
    logic        stall, mRD, mWR, fault;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rdata(rdata), .stall(stall), .mRD(mRD),
        .mWR(mWR), .DataAddr(DataAddr), .DataIn(DataIn), .DataOut(DataOut),
        .fault(fault), .fault_addr(fault_addr)
    );

    function automatic logic [31:0] pat(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // DataMemory: combinational read, write on negedge, plus a backdoor port.
    logic [31:0] mem [DEPTH];
    bit          mem_init = 1'b0;
    logic        bd_en = 1'b0;
    int          bd_idx = 0;
    logic [31:0] bd_val = '0;

    always @(negedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else if (bd_en) mem[bd_idx] <= bd_val;
        else if (mWR && DataAddr < DEPTH) mem[DataAddr[IDX_W-1:0]] <= DataIn;
    end
    assign DataOut = (DataAddr < DEPTH) ? mem[DataAddr[IDX_W-1:0]] : 32'h0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: memory image, pending merged write, fault record.
    logic [31:0] m [DEPTH];
    bit          m_init = 1'b0;
    bit          pend = 1'b0;
    int          pend_idx = 0;
    logic [31:0] pend_word = '0;
    bit          mf = 1'b0;
    logic [31:0] mfa = '0;

    initial forever begin
        logic [31:0] e_rd, e_addr, e_din, w, a;
        logic        e_st, e_mrd, e_mwr, ck_addr, ck_din, ill;
        int          idx, sh;
        @(posedge CLK);
        #4;
        if (!m_init) begin
            for (int i = 0; i < DEPTH; i++) m[i] = pat(i);
            m_init = 1'b1;
        end
        if (!RST) begin
            pend = 1'b0; mf = 1'b0; mfa = '0;
            chk("rst_rdata", rdata, 0);
            chk("rst_stall", 32'(stall), 0);
            chk("rst_mRD", 32'(mRD), 0);
            chk("rst_mWR", 32'(mWR), 0);
            chk("rst_fault", 32'(fault), 0);
            chk("rst_fault_addr", fault_addr, 0);
        end else begin
            e_rd = 0; e_st = 0; e_mrd = 0; e_mwr = 0; e_addr = 0; e_din = 0;
            ck_addr = 1; ck_din = 1;
            a = req_addr;
            chk("fault", 32'(fault), 32'(mf));
            chk("fault_addr", fault_addr, mfa);
            if (pend) begin
                e_mwr = 1; e_addr = 32'(pend_idx); e_din = pend_word;
                m[pend_idx] = pend_word;
                pend = 0;
            end else if (req_valid) begin
                ill = (req_size == 2'b11) || (req_size == SZ_HALF && a[0])
                   || (req_size == SZ_WORD && a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
                if (ill) begin
                    ck_addr = 0; ck_din = 0;
                    if (!mf) mfa = a;
                    mf = 1;
                end else begin
                    idx = int'(a[31:2]);
                    e_addr = 32'(idx);
                    w = m[idx];
                    if (!req_we) begin
                        e_mrd = 1; ck_din = 0;
                        if (req_size == SZ_BYTE) begin
                            sh = 8 * (3 - int'(a[1:0]));
                            e_rd = {24'h0, w[sh +: 8]};
                            if (req_signed && w[sh+7]) e_rd[31:8] = '1;
                        end else if (req_size == SZ_HALF) begin
                            sh = 16 * (1 - int'(a[1]));
                            e_rd = {16'h0, w[sh +: 16]};
                            if (req_signed && w[sh+15]) e_rd[31:16] = '1;
                        end else e_rd = w;
                    end else if (req_size == SZ_WORD) begin
                        e_mwr = 1; e_din = req_wdata;
                        m[idx] = req_wdata;
                    end else begin
                        e_mrd = 1; e_st = 1; ck_din = 0;
                        if (req_size == SZ_BYTE) w[8*(3-int'(a[1:0])) +: 8] = req_wdata[7:0];
                        else                     w[16*(1-int'(a[1])) +: 16] = req_wdata[15:0];
                        pend = 1; pend_idx = idx; pend_word = w;
                    end
                end
            end
            chk("rdata", rdata, e_rd);
            chk("stall", 32'(stall), 32'(e_st));
            chk("mRD", 32'(mRD), 32'(e_mrd));
            chk("mWR", 32'(mWR), 32'(e_mwr));
            if (ck_addr) chk("DataAddr", DataAddr, e_addr);
            if (ck_din)  chk("DataIn", DataIn, e_din);
        end
        if (bd_en) m[bd_idx] = bd_val;
    end

    // Drive a request at posedge+1; return at posedge+3 for literal checks.
    task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
        @(posedge CLK);
        #1;
        req_valid = v; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        #2;
    endtask

    task automatic backdoor(input int i, input logic [31:0] v);
        @(posedge CLK);
        #1;
        req_valid = 0;
        bd_en = 1; bd_idx = i; bd_val = v;
        #6;
        bd_en = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          off;
        logic        held;
        RST = 0; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        @(posedge CLK);
        #3;
        chk("reset_rdata", rdata, 0);
        chk("reset_mWR", 32'(mWR), 0);
        chk("reset_DataAddr", DataAddr, 0);
        chk("reset_fault", 32'(fault), 0);
        @(posedge CLK);
        #1 RST = 1;

        // 1: signed byte load, big-endian lane 2 of 0x11223344
        backdoor(5, 32'h11223344);
        drive(1, 0, SZ_BYTE, 1, 32'h16, 0);
        chk("t1_lb_rdata", rdata, 32'h00000033);
        chk("t1_lb_stall", 32'(stall), 0);
        chk("t1_lb_mRD", 32'(mRD), 1);

        // 2: halfword loads, signed and unsigned
        backdoor(5, 32'h80FF0000);
        drive(1, 0, SZ_HALF, 1, 32'h14, 0);
        chk("t2_lh_rdata", rdata, 32'hFFFF80FF);
        drive(1, 0, SZ_HALF, 0, 32'h14, 0);
        chk("t2_lhu_rdata", rdata, 32'h000080FF);

        // 3: byte store read-modify-write
        backdoor(5, 32'h11223344);
        drive(1, 1, SZ_BYTE, 0, 32'h15, 32'hAA);
        chk("t3_A_mRD", 32'(mRD), 1);
        chk("t3_A_stall", 32'(stall), 1);
        chk("t3_A_mWR", 32'(mWR), 0);
        drive(1, 1, SZ_BYTE, 0, 32'h15, 32'hAA);
        chk("t3_B_mWR", 32'(mWR), 1);
        chk("t3_B_DataIn", DataIn, 32'h11AA3344);
        chk("t3_B_stall", 32'(stall), 0);
        drive(1, 0, SZ_WORD, 0, 32'h14, 0);
        chk("t3_lw_rdata", rdata, 32'h11AA3344);

        // 4: word store to word 128
        backdoor(128, 32'h0);
        drive(1, 1, SZ_WORD, 0, 32'h200, 32'h1);
        chk("t4_mWR", 32'(mWR), 1);
        chk("t4_DataAddr", DataAddr, 128);
        chk("t4_stall", 32'(stall), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_led0", mem[128] & 32'h1, 32'h1);

        // 5: misaligned then out-of-range faults
        drive(1, 0, SZ_HALF, 0, 32'h13, 0);
        chk("t5_pre_fault", 32'(fault), 0);
        chk("t5_a_mRD", 32'(mRD), 0);
        chk("t5_a_mWR", 32'(mWR), 0);
        drive(1, 1, SZ_WORD, 0, 32'h1000, 32'h5);
        chk("t5_b_mRD", 32'(mRD), 0);
        chk("t5_b_mWR", 32'(mWR), 0);
        chk("t5_fault", 32'(fault), 1);
        chk("t5_fault_addr", fault_addr, 32'h13);
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_fault_addr_kept", fault_addr, 32'h13);

        // Randomized traffic; the request is held while stall is seen.
        held = 0;
        for (int n = 0; n < 600; n++) begin
            if (!held) begin
                sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                off = $urandom_range(0, 3);
                if (sz == SZ_HALF && $urandom_range(0, 3) != 0) off = off & 2;
                if (sz == SZ_WORD && $urandom_range(0, 3) != 0) off = 0;
                case ($urandom_range(0, 9))
                    0:       a = $urandom;
                    1:       a = 32'(((DEPTH - 1 + $urandom_range(0, 2)) * 4) + off);
                    default: a = 32'(($urandom_range(0, DEPTH - 1) * 4) + off);
                endcase
                drive($urandom_range(0, 3) != 0, 1'($urandom), sz, 1'($urandom), a, $urandom);
            end else drive(req_valid, req_we, req_size, req_signed, req_addr, req_wdata);
            held = stall;
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // 6: reset during cycle B of a halfword store
        backdoor(8, 32'hCAFEF00D);
        drive(1, 1, SZ_HALF, 0, 32'h20, 32'h1234);
        chk("t6_A_stall", 32'(stall), 1);
        chk("t6_pre_fault", 32'(fault), 1);
        @(posedge CLK);
        #1;
        chk("t6_B_mWR", 32'(mWR), 1);
        #1;
        RST = 0; req_valid = 0;
        #1;
        chk("t6_rst_mWR", 32'(mWR), 0);
        chk("t6_rst_fault", 32'(fault), 0);
        #3 RST = 1;
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_word8", mem[8], 32'hCAFEF00D);
        chk("t6_idle_mWR", 32'(mWR), 0);
        drive(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
